// File: rtl/product_accum_pkg.sv
// ---------------------------------------------------------------------------
// product_accum_pkg
// Shared definitions for the multiplier-path accumulator:
//   - default accumulator and count widths
//   - width of the product bus coming from the multiplier stage
//   - FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
// ---------------------------------------------------------------------------
package product_accum_pkg;

    localparam int ACC_W_DEF = 72;  // accumulator width, minimum 64
    localparam int CNT_W_DEF = 8;   // batch length / count width
    localparam int PROD_W    = 64;  // unsigned product width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accum.sv
// ---------------------------------------------------------------------------
// product_accum
// Sums a batch of unsigned 64-bit products into an ACC_W-bit accumulator.
// A batch starts with a single-cycle start pulse in IDLE, accepts batch_len
// products through a valid/ready handshake, then pulses done for one cycle.
//
// Handshake: a product is transferred on exactly those rising edges where
// prod_valid and prod_ready are both 1. prod_ready depends only on state,
// never on prod_valid, and nothing is buffered: a product offered while
// prod_ready is 0 is simply ignored.
//
// Ports:
//   clk         in   clock, all state updates on rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin a batch (honoured only in IDLE)
//   batch_len   in   CNT_W  products in the batch, sampled with start
//   prod_valid  in   product valid
//   product     in   64     unsigned product
//   prod_ready  out  accepting products (ACCUM only)
//   sum         out  ACC_W  running / final sum
//   count       out  CNT_W  products accepted this batch
//   overflow    out  sticky carry out of bit ACC_W-1 this batch
//   busy        out  high in ACCUM and DONE
//   done        out  one-cycle completion pulse
//   dbg_state   out  current FSM state for observation
// ---------------------------------------------------------------------------
module product_accum
    import product_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  batch_len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] product,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_len;
    logic [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic [ACC_W:0]     w_add;
    logic [CNT_W-1:0]   w_count_inc;

    // Ready is a pure function of state so the producer never sees a
    // combinational path from its own valid back to ready.
    assign prod_ready  = (r_state == S_ACCUM);
    assign w_accept    = prod_valid & prod_ready;

    // One extra bit on top of the accumulator captures the carry out.
    assign w_add       = {1'b0, r_sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    assign w_count_inc = r_count + {{(CNT_W - 1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= batch_len;
                        r_sum   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        // An empty batch completes without ever accepting.
                        if (batch_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_add[ACC_W-1:0];
                        r_ovf   <= r_ovf | w_add[ACC_W];
                        r_count <= w_count_inc;
                        if (w_count_inc == r_len) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_product_accum.sv
// ---------------------------------------------------------------------------
// tb_product_accum
// Drives two instances (ACC_W=72 and ACC_W=64) with identical stimulus and
// compares every output, every cycle, against a transaction-level model of
// a batch. Directed scenarios pin the model with hand-computed values, then
// a randomized phase mixes starts, gaps, resets and large products.
// ---------------------------------------------------------------------------
module tb_product_accum;

    localparam int CW = 8;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic          rst;
    logic          start;
    logic [CW-1:0] batch_len;
    logic          prod_valid;
    logic [63:0]   product;

    // ---------------- DUT outputs ----------------
    logic          a_ready, a_ovf, a_busy, a_done;
    logic [71:0]   a_sum;
    logic [CW-1:0] a_count;
    logic [1:0]    a_state;

    logic          b_ready, b_ovf, b_busy, b_done;
    logic [63:0]   b_sum;
    logic [CW-1:0] b_count;
    logic [1:0]    b_state;

    product_accum #(.ACC_W(72), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .batch_len(batch_len),
        .prod_valid(prod_valid), .product(product),
        .prod_ready(a_ready), .sum(a_sum), .count(a_count),
        .overflow(a_ovf), .busy(a_busy), .done(a_done), .dbg_state(a_state)
    );

    product_accum #(.ACC_W(64), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start), .batch_len(batch_len),
        .prod_valid(prod_valid), .product(product),
        .prod_ready(b_ready), .sum(b_sum), .count(b_count),
        .overflow(b_ovf), .busy(b_busy), .done(b_done), .dbg_state(b_state)
    );

    // ---------------- behavioural model ----------------
    // A batch is either being collected (m_active), finishing this cycle
    // (m_finishing), or absent. Sums are kept per accumulator width.
    bit          m_active;
    bit          m_finishing;
    int          m_len;
    int          m_cnt;
    logic [71:0] m_sum_a;
    logic [63:0] m_sum_b;
    bit          m_ovf_a;
    bit          m_ovf_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Advances the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        logic [72:0] ta;
        logic [64:0] tb;
        if (rst) begin
            m_active = 0; m_finishing = 0; m_len = 0; m_cnt = 0;
            m_sum_a = '0; m_sum_b = '0; m_ovf_a = 0; m_ovf_b = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
        end else if (m_active) begin
            if (prod_valid) begin
                ta = {1'b0, m_sum_a} + {9'b0, product};
                tb = {1'b0, m_sum_b} + {1'b0, product};
                m_ovf_a = m_ovf_a | ta[72];
                m_ovf_b = m_ovf_b | tb[64];
                m_sum_a = ta[71:0];
                m_sum_b = tb[63:0];
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_active = 0;
                    m_finishing = 1;
                end
            end
        end else if (start) begin
            m_len = int'(batch_len);
            m_cnt = 0;
            m_sum_a = '0; m_sum_b = '0; m_ovf_a = 0; m_ovf_b = 0;
            if (m_len == 0) m_finishing = 1;
            else            m_active = 1;
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = m_finishing ? 2 : (m_active ? 1 : 0);
        chk("a_ready", a_ready, m_active);
        chk("a_sum",   a_sum,   m_sum_a);
        chk("a_count", a_count, m_cnt);
        chk("a_ovf",   a_ovf,   m_ovf_a);
        chk("a_busy",  a_busy,  m_active | m_finishing);
        chk("a_done",  a_done,  m_finishing);
        chk("a_state", a_state, exp_state);
        chk("b_ready", b_ready, m_active);
        chk("b_sum",   b_sum,   m_sum_b);
        chk("b_count", b_count, m_cnt);
        chk("b_ovf",   b_ovf,   m_ovf_b);
        chk("b_busy",  b_busy,  m_active | m_finishing);
        chk("b_done",  b_done,  m_finishing);
        chk("b_state", b_state, exp_state);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit s, input logic [CW-1:0] l,
                         input bit v, input logic [63:0] p);
        rst = r; start = s; batch_len = l; prod_valid = v; product = p;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    localparam logic [63:0] BIG_P = 64'hFFFF_FFFE_0000_0001;

    initial begin
        rst = 1'b1; start = 1'b0; batch_len = '0; prod_valid = 1'b0; product = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 5, 1, 64'd9);
        chk("reset_ready", a_ready, 1'b0);
        chk("reset_sum",   a_sum, 72'd0);
        cycle(0, 0, 0, 0, 0);

        // Basic batch: 15 + 10000 + 41
        cycle(0, 1, 3, 0, 0);
        cycle(0, 0, 0, 1, 64'd15);
        cycle(0, 0, 0, 1, 64'd10000);
        chk("basic_no_early_done", a_done, 1'b0);
        cycle(0, 0, 0, 1, 64'd41);
        chk("basic_done",  a_done,  1'b1);
        chk("basic_sum",   a_sum,   72'd10056);
        chk("basic_model", m_sum_a, 72'd10056);
        chk("basic_count", a_count, 8'd3);
        chk("basic_ovf",   a_ovf,   1'b0);
        cycle(0, 0, 0, 1, 64'd77);
        chk("basic_hold",  a_sum,   72'd10056);

        // Maximum values: 255 products of BIG_P
        cycle(0, 1, 8'd255, 0, 0);
        for (int i = 0; i < 255; i++) cycle(0, 0, 0, 1, BIG_P);
        chk("max_sum",   a_sum,   72'hFE_FFFF_FE02_0000_00FF);
        chk("max_model", m_sum_a, 72'hFE_FFFF_FE02_0000_00FF);
        chk("max_ovf",   a_ovf,   1'b0);
        chk("max_count", a_count, 8'd255);
        cycle(0, 0, 0, 0, 0);

        // Wrap in the 64-bit instance
        cycle(0, 1, 2, 0, 0);
        cycle(0, 0, 0, 1, BIG_P);
        cycle(0, 0, 0, 1, BIG_P);
        chk("wrap_sum64",  b_sum, 64'hFFFF_FFFC_0000_0002);
        chk("wrap_ovf64",  b_ovf, 1'b1);
        chk("wrap_sum72",  a_sum, 72'h01_FFFF_FFFC_0000_0002);
        chk("wrap_ovf72",  a_ovf, 1'b0);
        cycle(0, 0, 0, 0, 0);

        // Zero length
        cycle(0, 1, 0, 1, 64'd123);
        chk("zero_done",  a_done,  1'b1);
        chk("zero_ready", a_ready, 1'b0);
        chk("zero_sum",   a_sum,   72'd0);
        cycle(0, 0, 0, 1, 64'd123);
        chk("zero_ready2", a_ready, 1'b0);

        // Gaps and ignored start
        cycle(0, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 64'd5555);
        cycle(0, 0, 0, 1, 64'd100);
        cycle(0, 1, 9, 0, 64'd8888);
        cycle(0, 0, 0, 0, 64'd7777);
        cycle(0, 1, 9, 1, 64'd23);
        chk("gap_sum",   a_sum,   72'd123);
        chk("gap_count", a_count, 8'd2);
        chk("gap_done",  a_done,  1'b1);
        cycle(0, 0, 0, 1, 64'd999);
        chk("gap_hold",  a_sum,   72'd123);

        // Reset mid-batch, with a simultaneous offered product
        cycle(0, 1, 3, 0, 0);
        cycle(0, 0, 0, 1, 64'd500);
        cycle(1, 1, 3, 1, 64'd7);
        chk("midrst_state", a_state, 2'd0);
        chk("midrst_sum",   a_sum,   72'd0);
        chk("midrst_count", a_count, 8'd0);
        chk("midrst_done",  a_done,  1'b0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 64'd5);
        chk("after_rst_sum",  a_sum,  72'd5);
        chk("after_rst_done", a_done, 1'b1);
        cycle(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit          r, s, v;
            logic [63:0] p;
            logic [CW-1:0] l;
            r = ($urandom_range(0, 60) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 1) == 1);
            l = CW'($urandom_range(0, 6));
            case ($urandom_range(0, 3))
                0:       p = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       p = 64'($urandom_range(0, 1000));
                default: p = {$urandom(), $urandom()};
            endcase
            cycle(r, s, l, v, p);
        end

        cycle(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/product_accum.md
PRODUCT_ACCUM -- requirements
Module: product_accum

Interface
REQ-001 Parameter ACC_W, default 72: accumulator width in bits, minimum 64.
REQ-002 Parameter CNT_W, default 8: width of the batch-length and count fields.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  single-cycle request to begin a batch; honoured only in IDLE.
REQ-006 batch_len  input  CNT_W  number of products in the batch; sampled when start is honoured.
REQ-007 prod_valid  input  1  product is valid this cycle.
REQ-008 product  input  64  unsigned 64-bit product from the multiplier stage.
REQ-009 prod_ready  output  1  block accepts product this cycle.
REQ-010 sum  output  ACC_W  running or final accumulated sum.
REQ-011 count  output  CNT_W  number of products accepted in the current batch.
REQ-012 overflow  output  1  sticky flag: carry out of bit ACC_W-1 occurred in this batch.
REQ-013 busy  output  1  high in ACCUM and DONE.
REQ-014 done  output  1  single-cycle pulse marking batch completion.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-016 In IDLE, start=1 SHALL do the following: latch batch_len; clear sum, count and overflow; go to DONE if batch_len==0, else to ACCUM.
REQ-017 prod_ready SHALL be 1 only in ACCUM, driven combinationally from state.
REQ-018 A product SHALL be accepted only on a cycle where prod_valid and prod_ready are both 1.
REQ-019 On acceptance, the block SHALL set sum <= (sum + zero-extended product) mod 2^ACC_W and count <= count+1.
REQ-020 Any carry out of the ACC_W-bit add SHALL set overflow, which remains set until the next honoured start or reset.
REQ-021 The acceptance that makes count equal the latched length SHALL move the state to DONE; sum and count are final on the following cycle.
REQ-022 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE on the next cycle.
REQ-023 Latency: done SHALL assert one cycle after the final accepting handshake, or one cycle after start when batch_len==0.
REQ-024 start SHALL be ignored in ACCUM and DONE; batch_len SHALL be ignored outside the start cycle.
REQ-025 prod_valid SHALL be ignored whenever prod_ready=0; no product is buffered.
REQ-026 sum, count and overflow SHALL hold their final values in IDLE until the next honoured start.
REQ-027 In ACCUM, cycles with prod_valid=0 SHALL leave all state unchanged; there is no timeout.

Reset
REQ-028 rst=1 SHALL, at the clock edge, force state=IDLE, sum=0, count=0, overflow=0, done=0, busy=0, prod_ready=0, and the latched length to 0.
REQ-029 rst SHALL take priority over start and over a simultaneous product acceptance.
REQ-030 Reset mid-batch SHALL discard the partial sum; no done pulse is generated for that batch.

Structure
REQ-031 State encodings (IDLE=0, ACCUM=1, DONE=2) and the ACC_W/CNT_W defaults SHALL live in the shared multiplier-path package/include.
REQ-032 The block SHALL be a single module with no sub-modules; the ACC_W+1-bit add SHALL be inline.

Verification
REQ-033 Basic batch: start with batch_len=3; products 15, 10000, 41, one per cycle -> sum=10056, count=3, overflow=0; done pulses once, one cycle after the third accept.
REQ-034 Maximum values: ACC_W=72, batch_len=255, each product 0xFFFFFFFE00000001 -> sum=0xFEFFFFFE02000000FF, overflow=0.
REQ-035 Wrap: ACC_W=64, batch_len=2, each product 0xFFFFFFFE00000001 -> sum=0xFFFFFFFC00000002, overflow=1.
REQ-036 Zero length: start with batch_len=0 -> done=1 on the next cycle, sum=0, prod_ready stays 0 throughout.
REQ-037 Gaps and ignored start: batch_len=2; prod_valid toggled with idle gaps; start pulsed during ACCUM -> only the two valid products are summed and the extra start has no effect.
REQ-038 Reset mid-batch: rst after 1 of 3 products -> next cycle state=IDLE, sum=0, count=0; no done pulse; a following batch is unaffected.
